// File: rtl/uart_load_pkg.sv
// Shared types and constants for the UART program/data loader.
package uart_load_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GET_CNT,
      ST_GET_HI,
      ST_GET_LO,
      ST_RUN
   } state_e;

   localparam logic [7:0] HDR_STOP      = 8'hA0;
   localparam logic [7:0] HDR_LOAD_INST = 8'hA1;
   localparam logic [7:0] HDR_LOAD_MEM  = 8'hA2;
   localparam logic [7:0] HDR_RUN       = 8'hA5;

   localparam logic [1:0] UART_SEL_IDLE = 2'd0;
   localparam logic [1:0] UART_SEL_MEM  = 2'd1;
   localparam logic [1:0] UART_SEL_INST = 2'd2;

endpackage

// File: rtl/uart_load_ctrl_if.sv
// Loader-side bundle: UART RX/TX byte handshakes, datapath load port and CPU control.
interface uart_load_ctrl_if;

   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        tx_ready;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        uart_en;
   logic [1:0]  uart_sel;
   logic [15:0] uart_data;
   logic        cpu_reset;
   logic        cpu_done;
   logic        busy;

   modport master (
      input  rx_valid, rx_data, tx_ready, cpu_done,
      output tx_valid, tx_data, uart_en, uart_sel, uart_data, cpu_reset, busy
   );

   modport slave (
      output rx_valid, rx_data, tx_ready, cpu_done,
      input  tx_valid, tx_data, uart_en, uart_sel, uart_data, cpu_reset, busy
   );

endinterface

// File: rtl/load_timeout_cnt.sv
// Inter-byte watchdog: counts idle cycles while enabled, flags expiry at TIMEOUT_CYC.
module load_timeout_cnt #(
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic clk,
   input  logic reset,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYC);

   logic [W-1:0] cnt_q, cnt_d;

   // Saturates at LIMIT so a stalled FSM never sees the count wrap back to zero.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i || !en_i)   cnt_d = '0;
      else if (cnt_q != LIMIT) cnt_d = cnt_q + W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign expire_o = en_i && (cnt_q == LIMIT);

endmodule

// File: rtl/uart_load_ctrl.sv
// Byte-stream command parser: loads instruction/data words, runs/stops the CPU, acks on TX.
module uart_load_ctrl
   import uart_load_pkg::*;
#(
   parameter int         TIMEOUT_CYC = 50000,
   parameter logic [7:0] ACK_OK      = 8'h55,
   parameter logic [7:0] ACK_ERR     = 8'hEE
) (
   input logic             clk,
   input logic             reset,
   uart_load_ctrl_if.master bus
);

   state_e      state_q;
   logic [1:0]  sel_q;
   logic [7:0]  remaining_q;
   logic [7:0]  hi_q;
   logic        uart_en_q;
   logic [1:0]  uart_sel_q;
   logic [15:0] uart_data_q;
   logic        tx_valid_q;
   logic [7:0]  tx_data_q;
   logic        to_en, to_expire;

   assign to_en = (state_q == ST_GET_CNT) || (state_q == ST_GET_HI) || (state_q == ST_GET_LO);

   load_timeout_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
      .clk      (clk),
      .reset    (reset),
      .clr_i    (bus.rx_valid),
      .en_i     (to_en),
      .expire_o (to_expire)
   );

   // A received byte always takes priority over an expiry in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         sel_q       <= UART_SEL_IDLE;
         remaining_q <= '0;
         hi_q        <= '0;
         uart_en_q   <= 1'b0;
         uart_sel_q  <= UART_SEL_IDLE;
         uart_data_q <= '0;
         tx_valid_q  <= 1'b0;
         tx_data_q   <= '0;
      end else begin
         uart_en_q   <= 1'b0;
         uart_sel_q  <= UART_SEL_IDLE;
         uart_data_q <= '0;
         if (tx_valid_q && bus.tx_ready) tx_valid_q <= 1'b0;

         case (state_q)
            ST_IDLE: if (bus.rx_valid) begin
               case (bus.rx_data)
                  HDR_LOAD_INST: begin sel_q <= UART_SEL_INST; state_q <= ST_GET_CNT; end
                  HDR_LOAD_MEM:  begin sel_q <= UART_SEL_MEM;  state_q <= ST_GET_CNT; end
                  HDR_RUN:  begin state_q <= ST_RUN; tx_valid_q <= 1'b1; tx_data_q <= ACK_OK; end
                  HDR_STOP: begin tx_valid_q <= 1'b1; tx_data_q <= ACK_OK; end
                  default:  begin tx_valid_q <= 1'b1; tx_data_q <= ACK_ERR; end
               endcase
            end
            ST_GET_CNT: if (bus.rx_valid) begin
               if (bus.rx_data == 8'd0) begin
                  state_q <= ST_IDLE; tx_valid_q <= 1'b1; tx_data_q <= ACK_OK;
               end else begin
                  remaining_q <= bus.rx_data; state_q <= ST_GET_HI;
               end
            end else if (to_expire) begin
               state_q <= ST_IDLE; tx_valid_q <= 1'b1; tx_data_q <= ACK_ERR;
            end
            ST_GET_HI: if (bus.rx_valid) begin
               hi_q <= bus.rx_data; state_q <= ST_GET_LO;
            end else if (to_expire) begin
               state_q <= ST_IDLE; tx_valid_q <= 1'b1; tx_data_q <= ACK_ERR;
            end
            ST_GET_LO: if (bus.rx_valid) begin
               uart_en_q   <= 1'b1;
               uart_sel_q  <= sel_q;
               uart_data_q <= {hi_q, bus.rx_data};
               remaining_q <= remaining_q - 8'd1;
               if (remaining_q == 8'd1) begin
                  state_q <= ST_IDLE; tx_valid_q <= 1'b1; tx_data_q <= ACK_OK;
               end else begin
                  state_q <= ST_GET_HI;
               end
            end else if (to_expire) begin
               state_q <= ST_IDLE; tx_valid_q <= 1'b1; tx_data_q <= ACK_ERR;
            end
            ST_RUN: if ((bus.rx_valid && bus.rx_data == HDR_STOP) || bus.cpu_done) begin
               state_q <= ST_IDLE; tx_valid_q <= 1'b1; tx_data_q <= ACK_OK;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.uart_en   = uart_en_q;
   assign bus.uart_sel  = uart_sel_q;
   assign bus.uart_data = uart_data_q;
   assign bus.tx_valid  = tx_valid_q;
   assign bus.tx_data   = tx_data_q;
   assign bus.cpu_reset = (state_q != ST_RUN);
   assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_load_ctrl.sv
// Directed bench for uart_load_ctrl: load frames, run/stop, errors, timeout, reset, ack backpressure.
module tb_uart_load_ctrl;

   localparam int TO = 16;

   logic clk = 1'b0;
   logic reset;
   int   n_chk = 0, n_fail = 0, idle_bad = 0;
   logic [17:0] wq[$];
   logic [7:0]  aq[$];

   uart_load_ctrl_if bus();

   uart_load_ctrl #(.TIMEOUT_CYC(TO), .ACK_OK(8'h55), .ACK_ERR(8'hEE)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   // Record every word strobe and every accepted ack; flag stray sel/data outside the strobe.
   always @(negedge clk) begin
      if (bus.uart_en) wq.push_back({bus.uart_sel, bus.uart_data});
      else if (bus.uart_sel != 2'd0 || bus.uart_data != 16'd0) idle_bad++;
      if (bus.tx_valid && bus.tx_ready) aq.push_back(bus.tx_data);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      tick();
      bus.rx_valid = 1'b0;
   endtask

   task automatic clrq();
      wq.delete();
      aq.delete();
   endtask

   function automatic logic [31:0] wget(input int i);
      return (wq.size() > i) ? {14'd0, wq[i]} : 32'hDEAD_BEEF;
   endfunction

   function automatic logic [31:0] aget(input int i);
      return (aq.size() > i) ? {24'd0, aq[i]} : 32'hDEAD_BEEF;
   endfunction

   task automatic chk_reset_vals(input string pfx);
      chk({pfx, "_tx_valid"},  bus.tx_valid,  0);
      chk({pfx, "_tx_data"},   bus.tx_data,   0);
      chk({pfx, "_uart_en"},   bus.uart_en,   0);
      chk({pfx, "_uart_sel"},  bus.uart_sel,  0);
      chk({pfx, "_uart_data"}, bus.uart_data, 0);
      chk({pfx, "_cpu_reset"}, bus.cpu_reset, 1);
      chk({pfx, "_busy"},      bus.busy,      0);
   endtask

   initial begin
      reset = 1'b1;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      bus.tx_ready = 1'b1;
      bus.cpu_done = 1'b0;
      tick(3);
      chk_reset_vals("rst");
      reset = 1'b0;
      tick();

      // LOAD_INST with two words, second byte pair arrives while first strobe is high
      clrq();
      send(8'hA1);
      chk("inst_busy", bus.busy, 1);
      send(8'h02); send(8'h12); send(8'h34); send(8'hAB); send(8'hCD);
      tick(3);
      chk("inst_nwords", wq.size(), 2);
      chk("inst_w0", wget(0), 32'h2_1234);
      chk("inst_w1", wget(1), 32'h2_ABCD);
      chk("inst_nack", aq.size(), 1);
      chk("inst_ack", aget(0), 8'h55);
      chk("inst_idle", bus.busy, 0);

      // LOAD_MEM with zero count
      clrq();
      send(8'hA2); send(8'h00);
      tick(3);
      chk("mem0_nwords", wq.size(), 0);
      chk("mem0_ack", aget(0), 8'h55);
      chk("mem0_busy", bus.busy, 0);

      // RUN ended by cpu_done; stray byte while running is ignored
      clrq();
      send(8'hA5);
      chk("run_cpu_reset", bus.cpu_reset, 0);
      chk("run_busy", bus.busy, 1);
      send(8'h12);
      tick(2);
      chk("run_nack", aq.size(), 1);
      chk("run_ack", aget(0), 8'h55);
      chk("run_still", bus.cpu_reset, 0);
      bus.cpu_done = 1'b1;
      tick();
      bus.cpu_done = 1'b0;
      chk("done_cpu_reset", bus.cpu_reset, 1);
      chk("done_busy", bus.busy, 0);
      tick(2);
      chk("done_nack", aq.size(), 2);
      chk("done_ack", aget(1), 8'h55);

      // RUN ended by STOP header
      clrq();
      send(8'hA5);
      tick();
      send(8'hA0);
      chk("stop_cpu_reset", bus.cpu_reset, 1);
      tick(2);
      chk("stop_nack", aq.size(), 2);
      chk("stop_ack", aget(1), 8'h55);

      // Bad header
      clrq();
      send(8'h7F);
      tick(2);
      chk("bad_ack", aget(0), 8'hEE);
      chk("bad_busy", bus.busy, 0);

      // Timeout between hi and lo: still busy after TO idle cycles, aborts on the next
      clrq();
      send(8'hA1); send(8'h01); send(8'h12);
      tick(TO);
      chk("to_edge_busy", bus.busy, 1);
      chk("to_edge_txv", bus.tx_valid, 0);
      tick();
      chk("to_busy", bus.busy, 0);
      chk("to_txv", bus.tx_valid, 1);
      chk("to_txd", bus.tx_data, 8'hEE);
      tick(2);
      chk("to_nwords", wq.size(), 0);
      chk("to_ack", aget(0), 8'hEE);

      // Reset between hi and lo, then a clean frame
      clrq();
      send(8'hA1); send(8'h01); send(8'h12);
      reset = 1'b1;
      tick();
      chk_reset_vals("midrst");
      reset = 1'b0;
      tick(2);
      chk("midrst_nack", aq.size(), 0);
      chk("midrst_nwords", wq.size(), 0);
      send(8'hA1); send(8'h01); send(8'hBE); send(8'hEF);
      tick(3);
      chk("post_nwords", wq.size(), 1);
      chk("post_w0", wget(0), 32'h2_BEEF);
      chk("post_ack", aget(0), 8'h55);

      // Two acks under backpressure: latest status wins, one accept drains it
      clrq();
      bus.tx_ready = 1'b0;
      send(8'h7F);
      send(8'hA0);
      tick(2);
      chk("bp_txv", bus.tx_valid, 1);
      chk("bp_txd", bus.tx_data, 8'h55);
      chk("bp_nack", aq.size(), 0);
      bus.tx_ready = 1'b1;
      tick();
      chk("bp_clear", bus.tx_valid, 0);
      chk("bp_acc_n", aq.size(), 1);
      chk("bp_acc", aget(0), 8'h55);

      chk("idle_sel_data", idle_bad, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
